// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader placed in front of the CPU core.
// Receives a framed byte stream (HDR, LEN, LEN payload bytes, CSUM) over a
// valid/ready handshake and writes the payload into the CPU memory starting
// at address 0. The CPU is released from reset only when the 8-bit additive
// checksum of the payload matches; otherwise it stays in reset and err is set.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream byte valid
//   in_data    in   upstream byte
//   in_ready   out  loader accepts a byte (IDLE, LEN, DATA, CSUM)
//   restart    in   one-cycle pulse, re-arms the loader from RUN or ERR
//   mem_we     out  registered memory write strobe, one cycle per payload byte
//   mem_addr   out  registered memory write address
//   mem_wdata  out  registered memory write data
//   cpu_reset  out  registered CPU reset, 1 = CPU held in reset
//   done       out  registered, load succeeded and CPU running
//   err        out  registered, load failed (zero length or bad checksum)
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] HDR = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [DATA_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0]  sum_r, sum_s;
  logic               we_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]  wdata_s;
  logic               accept_s;
  logic [ADDR_W-1:0]  last_idx_s;

  // Ready is a pure decode of the state register: the loader stops
  // accepting bytes once it has reached a final state.
  assign in_ready = (state_r == S_IDLE) || (state_r == S_LEN) ||
                    (state_r == S_DATA) || (state_r == S_CSUM);

  assign accept_s   = in_valid && in_ready;
  assign last_idx_s = ADDR_W'(cnt_r - {{(DATA_W-1){1'b0}}, 1'b1});

  // Next-state, frame bookkeeping and write-port next values.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    sum_s   = sum_r;
    we_s    = 1'b0;
    addr_s  = mem_addr;
    wdata_s = mem_wdata;
    case (state_r)
      S_IDLE: begin
        if (accept_s && (in_data == HDR)) begin
          state_s = S_LEN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LEN: begin
        if (accept_s) begin
          if (in_data == {DATA_W{1'b0}}) begin
            state_s = S_ERR;
          end else begin
            cnt_s   = in_data;
            idx_s   = {ADDR_W{1'b0}};
            sum_s   = {DATA_W{1'b0}};
            state_s = S_DATA;
          end
        end else begin
          state_s = S_LEN;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          we_s    = 1'b1;
          addr_s  = idx_r;
          wdata_s = in_data;
          sum_s   = sum_r + in_data;
          // idx is left at the last address instead of stepping past LEN-1.
          if (idx_r == last_idx_s) begin
            state_s = S_CSUM;
          end else begin
            idx_s   = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_s = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept_s) begin
          if (in_data == sum_r) begin
            state_s = S_RUN;
          end else begin
            state_s = S_ERR;
          end
        end else begin
          state_s = S_CSUM;
        end
      end
      S_RUN: begin
        if (restart) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_ERR: begin
        if (restart) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_ERR;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame counters and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {DATA_W{1'b0}};
      idx_r <= {ADDR_W{1'b0}};
      sum_r <= {DATA_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
      idx_r <= idx_s;
      sum_r <= sum_s;
    end
  end

  // Registered memory write port; address and data hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      mem_we    <= we_s;
      mem_addr  <= addr_s;
      mem_wdata <= wdata_s;
    end
  end

  // Status outputs are registered from the next state so they change on
  // the same edge the state register enters RUN or ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cpu_reset <= (state_s != S_RUN);
      done      <= (state_s == S_RUN);
      err       <= (state_s == S_ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader. Inputs change on the falling edge,
// outputs are sampled on the falling edge; every write strobe is logged
// with its cycle number and compared against hand-computed expectations.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       restart = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int wn     = 0;
  int wa [64];
  int wd [64];
  int wc [64];
  int base;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log: one entry per observed strobe.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && wn < 64) begin
      wa[wn] = int'(mem_addr);
      wd[wn] = int'(mem_wdata);
      wc[wn] = cyc;
      wn = wn + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_write(input string tag, input int k, input int a, input int d);
    check({tag, "_addr"}, wa[base+k], a);
    check({tag, "_data"}, wd[base+k], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", int'(cpu_reset), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_ready", int'(in_ready), 1);
    reset = 1'b0;
    idle(2);

    // 1. Good frame, no gaps.
    base = wn;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("t1_cpu_reset_before", int'(cpu_reset), 1);
    send(8'h66);
    check("t1_done", int'(done), 1);
    check("t1_cpu_reset", int'(cpu_reset), 0);
    check("t1_ready", int'(in_ready), 0);
    check("t1_nwrites", wn - base, 3);
    check_write("t1_w0", 0, 8'h00, 8'h11);
    check_write("t1_w1", 1, 8'h01, 8'h22);
    check_write("t1_w2", 2, 8'h02, 8'h33);
    check("t1_consec01", wc[base+1] - wc[base], 1);
    check("t1_consec12", wc[base+2] - wc[base+1], 1);
    idle(2);
    check("t1_done_hold", int'(done), 1);
    pulse_restart();
    check("t1_rs_ready", int'(in_ready), 1);
    check("t1_rs_done", int'(done), 0);
    check("t1_rs_cpu_reset", int'(cpu_reset), 1);

    // 2. Bad checksum.
    base = wn;
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h04);
    idle(1);
    check("t2_err", int'(err), 1);
    check("t2_cpu_reset", int'(cpu_reset), 1);
    check("t2_ready", int'(in_ready), 0);
    check("t2_done", int'(done), 0);
    send(8'h55);
    idle(2);
    check("t2_nwrites", wn - base, 2);
    check_write("t2_w0", 0, 8'h00, 8'h01);
    check_write("t2_w1", 1, 8'h01, 8'h02);
    check("t2_err_hold", int'(err), 1);
    pulse_restart();
    check("t2_rs_err", int'(err), 0);
    check("t2_rs_ready", int'(in_ready), 1);

    // 3. Garbage before header.
    base = wn;
    check("t3_ready_g0", int'(in_ready), 1);
    send(8'h00);
    check("t3_ready_g1", int'(in_ready), 1);
    send(8'hFF);
    check("t3_ready_g2", int'(in_ready), 1);
    send(8'hA4);
    check("t3_ready_g3", int'(in_ready), 1);
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h7F);
    idle(1);
    check("t3_done", int'(done), 1);
    check("t3_nwrites", wn - base, 1);
    check_write("t3_w0", 0, 8'h00, 8'h7F);
    pulse_restart();

    // 4. Zero length.
    base = wn;
    send(8'hA5); send(8'h00);
    idle(2);
    check("t4_err", int'(err), 1);
    check("t4_nwrites", wn - base, 0);
    pulse_restart();
    check("t4_rs_err", int'(err), 0);
    check("t4_rs_ready", int'(in_ready), 1);
    check("t4_rs_cpu_reset", int'(cpu_reset), 1);

    // 5. Checksum wrap with random gaps.
    base = wn;
    send(8'hA5); idle($urandom_range(0, 3));
    send(8'h02); idle($urandom_range(0, 3));
    send(8'hFF); idle($urandom_range(1, 3));
    send(8'h03); idle($urandom_range(1, 3));
    send(8'h02);
    idle(2);
    check("t5_done", int'(done), 1);
    check("t5_err", int'(err), 0);
    check("t5_nwrites", wn - base, 2);
    check_write("t5_w0", 0, 8'h00, 8'hFF);
    check_write("t5_w1", 1, 8'h01, 8'h03);
    pulse_restart();

    // 6. Asynchronous reset mid-frame, then a fresh load.
    send(8'hA5); send(8'h04); send(8'hAA); send(8'hBB);
    check("t6_we_before", int'(mem_we), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_we", int'(mem_we), 0);
    check("t6_async_addr", int'(mem_addr), 0);
    check("t6_async_wdata", int'(mem_wdata), 0);
    check("t6_async_cpu_reset", int'(cpu_reset), 1);
    check("t6_async_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    base = wn;
    send(8'hA5); send(8'h02); send(8'h05); send(8'h06); send(8'h0B);
    idle(1);
    check("t6_done", int'(done), 1);
    check("t6_nwrites", wn - base, 2);
    check_write("t6_w0", 0, 8'h00, 8'h05);
    check_write("t6_w1", 1, 8'h01, 8'h06);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
